// File: rtl/div8_seq.sv
// rtl/div8_seq.sv - sequential restoring divider, 2N-bit dividend by N-bit divisor
module div8_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           dbz,
    output logic           ovf
);

    // Step counter width; a 1-bit counter keeps the degenerate N=1 case legal.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  rem_q, rem_d;       // partial remainder
    logic [N-1:0]  low_q, low_d;       // dividend low bits out, quotient bits in
    logic [N-1:0]  dvsr_q, dvsr_d;     // latched divisor
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  remo_q, remo_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;
    logic          vld_q, vld_d;

    logic [N:0]    step_t;
    logic          step_qbit;
    logic [N-1:0]  step_rem;

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = vld_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

    // One restoring step. The partial remainder is always below the divisor,
    // so when t >= divisor the difference fits in N bits and the carry bit
    // can be dropped before subtracting.
    always_comb begin
        step_t    = {rem_q, low_q[N-1]};
        step_qbit = (step_t >= {1'b0, dvsr_q});
        step_rem  = step_qbit ? (step_t[N-1:0] - dvsr_q) : step_t[N-1:0];
    end

    // Next-state and datapath control for IDLE/BUSY/DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        low_d   = low_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvsr_d = divisor;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        remo_d  = dividend[N-1:0];
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        vld_d   = 1'b1;
                    end else if (dividend[2*N-1:N] >= divisor) begin
                        state_d = DONE;
                        quot_d  = '1;
                        remo_d  = '0;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        vld_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                        rem_d   = dividend[2*N-1:N];
                        low_d   = dividend[N-1:0];
                        cnt_d   = '0;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                low_d = {low_q[N-2:0], step_qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    quot_d  = {low_q[N-2:0], step_qbit};
                    remo_d  = step_rem;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    vld_d   = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            low_q   <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            low_q   <= low_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: doc/div8_seq.md
DIV8_SEQ -- requirements
Module: div8_seq

Interface
REQ-001 SHALL have parameter N, default 8, operand width; dividend is 2N bits, divisor, quotient and remainder are N bits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: operands valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts operands; equals (state==IDLE) & ~rst.
REQ-006 SHALL have port dividend, input, 2N: unsigned dividend, sampled on acceptance.
REQ-007 SHALL have port divisor, input, N: unsigned divisor, sampled on acceptance.
REQ-008 SHALL have port out_valid, output, 1: result valid; registered.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port quotient, output, N: unsigned quotient; registered.
REQ-011 SHALL have port remainder, output, N: unsigned remainder; registered.
REQ-012 SHALL have port dbz, output, 1: divide-by-zero flag for the current result.
REQ-013 SHALL have port ovf, output, 1: quotient-overflow flag for the current result.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE, with a log2(N)-bit step counter.
REQ-015 SHALL define acceptance as the rising edge where in_valid & in_ready; operands are latched internally, and later input changes have no effect.
REQ-016 SHALL, on acceptance with divisor==0, go directly to DONE with quotient={N{1}}, remainder=dividend[N-1:0], dbz=1, ovf=0.
REQ-017 SHALL, on acceptance with divisor!=0 and dividend[2N-1:N]>=divisor, go directly to DONE with quotient={N{1}}, remainder=0, dbz=0, ovf=1.
REQ-018 SHALL, otherwise, enter BUSY with partial remainder=dividend[2N-1:N], low shift register=dividend[N-1:0], counter=0.
REQ-019 SHALL, each BUSY cycle, perform one restoring step: t = {rem, msb of low shift register} (N+1 bits); if t>=divisor, rem=t-divisor and quotient bit=1, else rem=t[N-1:0] and quotient bit=0; quotient bits shift in MSB-first.
REQ-020 SHALL, after exactly N BUSY cycles, enter DONE, load the quotient/remainder outputs and set dbz=0, ovf=0.
REQ-021 SHALL assert out_valid in the cycle after the DONE-entry edge: 1 cycle after acceptance for dbz/ovf, N cycles after acceptance for normal division.
REQ-022 SHALL hold out_valid, quotient, remainder, dbz and ovf stable in DONE until out_valid & out_ready.
REQ-023 SHALL, on that handshake edge, return to IDLE, deassert out_valid, and hold quotient/remainder/flags at their last values.
REQ-024 SHALL never accept new operands in the same cycle a result is consumed; in_ready rises the cycle after the handshake.
REQ-025 SHALL ignore out_ready outside DONE and in_valid outside IDLE.
REQ-026 SHALL satisfy dividend = quotient*divisor + remainder, with remainder<divisor, whenever dbz=0 and ovf=0.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, counter=0, out_valid=0, quotient=0, remainder=0, dbz=0, ovf=0, in_ready=0.
REQ-028 SHALL, on rst assertion mid-BUSY or mid-DONE, immediately abandon the operation; no result is ever delivered for it.
REQ-029 SHALL assert in_ready in the first cycle after rst deasserts.

Verification
REQ-030 SHALL cover: dividend=1000, divisor=7 -> out_valid 8 cycles after acceptance, quotient=142, remainder=6, dbz=0, ovf=0.
REQ-031 SHALL cover: dividend=0x00FF, divisor=1 -> quotient=255, remainder=0; then dividend=0x0000, divisor=200 -> quotient=0, remainder=0.
REQ-032 SHALL cover: divisor=0, dividend=0x1234 -> out_valid 1 cycle after acceptance, quotient=0xFF, remainder=0x34, dbz=1.
REQ-033 SHALL cover: dividend=0x0800, divisor=8 -> ovf=1, quotient=0xFF, remainder=0, out_valid 1 cycle after acceptance.
REQ-034 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable throughout, in_ready=0; out_ready pulse -> IDLE, in_ready=1 next cycle.
REQ-035 SHALL cover: rst pulsed at BUSY step 4 -> all outputs 0 immediately; the next operation 100/9 -> quotient=11, remainder=1.
